// File: rtl/instmem_loader_if.sv
// Host byte stream in, instruction-memory byte writes and boot status out.
// Handshake: a byte moves on a rising clk edge where in_valid && in_ready;
// the host holds in_data stable while in_valid is high and not yet accepted.
interface instmem_loader_if #(
  parameter int ADDR_WIDTH = 12
);
  logic [7:0]            in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [7:0]            mem_wdata;
  logic                  done;
  logic                  err;
  logic                  cpu_hold;

  // Host / bench side
  modport master (
    output in_data, in_valid,
    input  in_ready, mem_we, mem_addr, mem_wdata, done, err, cpu_hold
  );

  // Loader side
  modport slave (
    input  in_data, in_valid,
    output in_ready, mem_we, mem_addr, mem_wdata, done, err, cpu_hold
  );
endinterface

// File: rtl/instmem_loader.sv
// Byte-stream boot loader: parses SYNC/ADDR/LEN/PAYLOAD/CSUM frames,
// writes payload bytes into the instruction window and releases the CPU
// once a frame finishes with a zero modulo-256 checksum.
module instmem_loader #(
  parameter int          ADDR_WIDTH = 12,
  parameter logic [31:0] BASE_ADDR  = 32'hBFC00000,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
  input  logic               clk,
  input  logic               rst,
  instmem_loader_if.slave    bus,
  output logic [2:0]         o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ADDR    = 3'd1,
    S_LEN     = 3'd2,
    S_PAYLOAD = 3'd3,
    S_CSUM    = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [31:0]           r_addr;
  logic [7:0]            r_len_hi;
  logic [1:0]            r_cnt;
  logic [7:0]            r_csum;
  logic [ADDR_WIDTH-1:0] r_off;
  logic [15:0]           r_remain;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [7:0]            r_mem_wdata;
  logic                  r_err;
  logic                  r_cpu_hold;

  logic                  w_in_ready;
  logic                  w_acc;
  logic                  w_is_sync;
  logic [7:0]            w_csum_next;
  logic [15:0]           w_len_full;
  logic [32:0]           w_end;
  logic                  w_range_ok;

  // Not ready while in reset or during the single DONE cycle.
  assign w_in_ready  = ~rst & (r_state != S_DONE);
  assign w_acc       = bus.in_valid & w_in_ready;
  assign w_is_sync   = (bus.in_data == SYNC_BYTE);
  assign w_csum_next = r_csum + bus.in_data;
  // Full length as it stands once the second LEN byte is on the bus.
  assign w_len_full  = {r_len_hi, bus.in_data};
  // End offset computed wide so offset+LEN can never wrap past the window.
  assign w_end       = 33'(r_addr[ADDR_WIDTH-1:0]) + 33'(w_len_full);
  assign w_range_ok  = (r_addr[31:ADDR_WIDTH] == BASE_ADDR[31:ADDR_WIDTH]) &&
                       (w_end <= (33'd1 << ADDR_WIDTH));

  assign bus.in_ready  = w_in_ready;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.done      = (r_state == S_DONE);
  assign bus.err       = r_err;
  assign bus.cpu_hold  = r_cpu_hold;
  assign o_dbg_state   = r_state;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode of the frame format.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_acc && w_is_sync) w_next = S_ADDR;
      S_ADDR:    if (w_acc && r_cnt == 2'd3) w_next = S_LEN;
      S_LEN: begin
        if (w_acc && r_cnt == 2'd1) begin
          if (!w_range_ok)             w_next = S_IDLE;
          else if (w_len_full == 16'd0) w_next = S_CSUM;
          else                          w_next = S_PAYLOAD;
        end
      end
      S_PAYLOAD: if (w_acc && r_remain == 16'd1) w_next = S_CSUM;
      S_CSUM:    if (w_acc) w_next = (w_csum_next == 8'd0) ? S_DONE : S_IDLE;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Header capture, checksum, write strobe and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr      <= '0;
      r_len_hi    <= '0;
      r_cnt       <= '0;
      r_csum      <= '0;
      r_off       <= '0;
      r_remain    <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_err       <= 1'b0;
      r_cpu_hold  <= 1'b1;
    end else begin
      r_mem_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_acc && w_is_sync) begin
            r_csum     <= '0;
            r_err      <= 1'b0;
            r_cpu_hold <= 1'b1;
            r_cnt      <= '0;
          end
        end
        S_ADDR: begin
          if (w_acc) begin
            r_addr <= {r_addr[23:0], bus.in_data};
            r_csum <= w_csum_next;
            r_cnt  <= r_cnt + 2'd1;
          end
        end
        S_LEN: begin
          if (w_acc) begin
            r_len_hi <= bus.in_data;
            r_csum   <= w_csum_next;
            if (r_cnt == 2'd1) begin
              r_cnt <= '0;
              if (!w_range_ok) begin
                r_err <= 1'b1;
              end else begin
                r_off    <= r_addr[ADDR_WIDTH-1:0];
                r_remain <= w_len_full;
              end
            end else begin
              r_cnt <= r_cnt + 2'd1;
            end
          end
        end
        S_PAYLOAD: begin
          if (w_acc) begin
            r_mem_we    <= 1'b1;
            r_mem_addr  <= r_off;
            r_mem_wdata <= bus.in_data;
            r_off       <= r_off + 1'b1;
            r_remain    <= r_remain - 16'd1;
            r_csum      <= w_csum_next;
          end
        end
        S_CSUM: begin
          if (w_acc) begin
            r_csum <= w_csum_next;
            // Release the CPU together with the done pulse.
            if (w_csum_next == 8'd0) r_cpu_hold <= 1'b0;
            else                     r_err      <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instmem_loader.sv
// Bench for instmem_loader: frames are built from a byte-level model that
// predicts range checks, checksums and the exact sequence of memory writes.
module tb_instmem_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] dbg_state;

  instmem_loader_if #(.ADDR_WIDTH(12)) bus ();

  instmem_loader #(
    .ADDR_WIDTH(12),
    .BASE_ADDR (32'hBFC00000),
    .SYNC_BYTE (8'hA5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  logic [19:0] exp_q[$];
  logic        cur_pay = 1'b0;
  logic        r_exp_we = 1'b0;
  logic        mon_en = 1'b0;
  int          exp_off = 0;

  // Expected write strobe: one cycle after each accepted payload byte.
  always @(posedge clk) r_exp_we <= !rst && bus.in_valid && cur_pay;

  // Write monitor against the expected write queue.
  always @(negedge clk) begin
    logic [19:0] e;
    if (mon_en) begin
      n_checks++;
      if (bus.mem_we !== r_exp_we) begin
        n_fail++;
        $display("FAIL mem_we_timing t=%0t got=%b exp=%b", $time, bus.mem_we, r_exp_we);
      end
      if (bus.mem_we === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_write t=%0t addr=%h data=%h", $time, bus.mem_addr, bus.mem_wdata);
        end else begin
          e = exp_q.pop_front();
          if ({bus.mem_addr, bus.mem_wdata} !== e) begin
            n_fail++;
            $display("FAIL write_value t=%0t got=%h/%h exp=%h/%h", $time,
                     bus.mem_addr, bus.mem_wdata, e[19:8], e[7:0]);
          end
        end
      end
      if (bus.done === 1'b1) done_cnt++;
    end
  end

  // Drive one byte; returns just after the edge that accepts it.
  task automatic send_byte(input logic [7:0] b, input logic is_pay);
    int t;
    @(negedge clk);
    t = 0;
    while (bus.in_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      n_checks++;
      n_fail++;
      $display("FAIL ready_timeout t=%0t got=%b exp=1", $time, bus.in_ready);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    cur_pay      = is_pay;
    @(posedge clk);
    if (is_pay) begin
      exp_q.push_back({exp_off[11:0], b});
      exp_off++;
    end
    #1;
    bus.in_valid = 1'b0;
    cur_pay      = 1'b0;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
  endtask

  // One complete frame; the model decides range/checksum outcome.
  task automatic run_frame(input logic [31:0] addr, input logic [15:0] len,
                           input logic [7:0] pl[$], input logic [7:0] csum_xor,
                           input logic gaps, input string name);
    logic [7:0] sum;
    logic [7:0] b;
    logic       range_ok;
    logic       good;
    int         d0;
    int         njunk;
    sum = 8'd0;
    for (int i = 0; i < 4; i++) sum = sum + addr[31-8*i -: 8];
    sum = sum + len[15:8] + len[7:0];
    foreach (pl[i]) sum = sum + pl[i];
    range_ok = (addr[31:12] == 20'hBFC00) && (int'(addr[11:0]) + int'(len) <= 4096);
    good     = range_ok && (csum_xor == 8'd0);
    d0       = done_cnt;
    exp_off  = int'(addr[11:0]);

    send_byte(8'hA5, 1'b0);
    for (int i = 0; i < 4; i++) send_byte(addr[31-8*i -: 8], 1'b0);
    send_byte(len[15:8], 1'b0);
    send_byte(len[7:0], 1'b0);

    if (range_ok) begin
      foreach (pl[i]) begin
        if (gaps && i > 0) idle_cycle();
        send_byte(pl[i], 1'b1);
      end
      send_byte((8'd0 - sum) ^ csum_xor, 1'b0);
      @(negedge clk);
      n_checks++;
      if (bus.done !== good || bus.err !== !good || bus.cpu_hold !== !good) begin
        n_fail++;
        $display("FAIL %s_end got done=%b err=%b hold=%b exp done=%b err=%b hold=%b",
                 name, bus.done, bus.err, bus.cpu_hold, good, !good, !good);
      end
      @(negedge clk);
      n_checks++;
      if (bus.done !== 1'b0 || bus.cpu_hold !== !good || bus.in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL %s_after got done=%b hold=%b rdy=%b exp done=0 hold=%b rdy=1",
                 name, bus.done, bus.cpu_hold, bus.in_ready, !good);
      end
    end else begin
      @(negedge clk);
      n_checks++;
      if (bus.err !== 1'b1 || bus.cpu_hold !== 1'b1 || bus.done !== 1'b0) begin
        n_fail++;
        $display("FAIL %s_range got err=%b hold=%b done=%b exp err=1 hold=1 done=0",
                 name, bus.err, bus.cpu_hold, bus.done);
      end
      // Remaining host bytes are ignored in IDLE (non-SYNC values only).
      njunk = (len < 8) ? int'(len) : 8;
      for (int i = 0; i < njunk; i++) begin
        b = (i < pl.size()) ? pl[i] : 8'($urandom_range(0, 255));
        if (b == 8'hA5) b = 8'h5A;
        send_byte(b, 1'b0);
      end
      @(negedge clk);
      n_checks++;
      if (bus.err !== 1'b1 || bus.cpu_hold !== 1'b1) begin
        n_fail++;
        $display("FAIL %s_range_hold got err=%b hold=%b exp err=1 hold=1", name, bus.err, bus.cpu_hold);
      end
    end
    n_checks++;
    if (done_cnt - d0 !== (good ? 1 : 0)) begin
      n_fail++;
      $display("FAIL %s_done_count got=%0d exp=%0d", name, done_cnt - d0, good ? 1 : 0);
    end
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.in_ready !== 1'b0 || bus.mem_we !== 1'b0 || bus.mem_addr !== 12'h000 ||
        bus.mem_wdata !== 8'h00 || bus.done !== 1'b0 || bus.err !== 1'b0 || bus.cpu_hold !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_values got rdy=%b we=%b a=%h d=%h done=%b err=%b hold=%b exp 0 0 000 00 0 0 1",
               bus.in_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.done, bus.err, bus.cpu_hold);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready got=%b exp=1", bus.in_ready);
    end
    mon_en = 1'b1;
  endtask

  task automatic test_good_frame();
    logic [7:0] pl[$];
    pl = '{8'h01, 8'h02, 8'h03, 8'h04};
    run_frame(32'hBFC00000, 16'd4, pl, 8'h00, 1'b0, "good");
  endtask

  task automatic test_bad_csum();
    logic [7:0] pl[$];
    pl = '{8'h01, 8'h02, 8'h03, 8'h04};
    run_frame(32'hBFC00000, 16'd4, pl, 8'h07, 1'b0, "bad_csum");
  endtask

  task automatic test_range_errors();
    logic [7:0] pl[$];
    pl = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_frame(32'hBFC00FFE, 16'd4, pl, 8'h00, 1'b0, "range_end");
    pl = '{8'h55};
    run_frame(32'h80000000, 16'd1, pl, 8'h00, 1'b0, "range_window");
  endtask

  task automatic test_boundary();
    logic [7:0] pl[$];
    pl = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    run_frame(32'hBFC00FFC, 16'd4, pl, 8'h00, 1'b0, "boundary");
    pl = {};
    run_frame(32'hBFC00123, 16'd0, pl, 8'h00, 1'b0, "zero_len");
  endtask

  task automatic test_stream_gaps();
    logic [7:0] pl[$];
    pl = '{8'h01, 8'h02, 8'h03, 8'h04};
    send_byte(8'h00, 1'b0);
    send_byte(8'hFF, 1'b0);
    send_byte(8'h12, 1'b0);
    run_frame(32'hBFC00000, 16'd4, pl, 8'h00, 1'b1, "gaps");
  endtask

  task automatic test_reset_mid_payload();
    logic [7:0] pl[$];
    exp_off = 12'h100;
    send_byte(8'hA5, 1'b0);
    send_byte(8'hBF, 1'b0);
    send_byte(8'hC0, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h04, 1'b0);
    send_byte(8'h9A, 1'b1);
    send_byte(8'h9B, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.mem_we !== 1'b0 || bus.cpu_hold !== 1'b1 || bus.err !== 1'b0 || bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid got we=%b hold=%b err=%b rdy=%b exp we=0 hold=1 err=0 rdy=0",
               bus.mem_we, bus.cpu_hold, bus.err, bus.in_ready);
    end
    rst = 1'b0;
    pl = '{8'h0D, 8'hA5, 8'h77};
    run_frame(32'hBFC00200, 16'd3, pl, 8'h00, 1'b0, "after_rst");
  endtask

  task automatic test_random();
    logic [7:0]  pl[$];
    logic [15:0] len;
    logic [31:0] addr;
    logic [7:0]  cx;
    int          off;
    int          mode;
    for (int k = 0; k < 30; k++) begin
      len  = 16'($urandom_range(0, 20));
      mode = $urandom_range(0, 9);
      off  = $urandom_range(0, 4095);
      if (mode == 0 && len > 0) off = 4096 - int'(len);
      if (mode == 1 && len > 1) off = 4097 - int'(len);
      addr = {20'hBFC00, off[11:0]};
      if (mode == 2) begin
        addr[31:12] = 20'($urandom);
        if (addr[31:12] == 20'hBFC00) addr[31:12] = 20'hBFC01;
      end
      pl = {};
      for (int i = 0; i < int'(len); i++) pl.push_back(8'($urandom_range(0, 255)));
      cx = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      run_frame(addr, len, pl, cx, 1'($urandom_range(0, 1)), "random");
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_csum();
    test_range_errors();
    test_boundary();
    test_stream_gaps();
    test_reset_mid_payload();
    test_random();
    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_writes got=%0d pending exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
